// File: rtl/fifo_wptr_full.sv
// Write-domain side of an asynchronous FIFO: binary/Gray write pointers, RAM write
// port, and registered full, almost-full, level and sticky overflow flags.
module fifo_wptr_full #(
  parameter int ADDR_SIZE          = 4,
  parameter int ALMOST_FULL_THRESH = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 winc,
  input  logic [ADDR_SIZE:0]   wq2_rptr,
  output logic                 wen,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic [ADDR_SIZE:0]   wptr,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic [ADDR_SIZE:0]   wlevel,
  output logic                 wovf
);

  localparam int A = ADDR_SIZE;
  localparam logic [A:0] THRESH = (A+1)'(ALMOST_FULL_THRESH);

  logic [A:0] wbin_q, wbin_d;
  logic [A:0] wptr_q, wptr_d;
  logic [A:0] wlevel_q, wlevel_d;
  logic [A:0] rbin_s;
  logic       wfull_q, wfull_d;
  logic       walmost_full_q, walmost_full_d;
  logic       wovf_q, wovf_d;

  // Registered full gates the write, so a changing wq2_rptr cannot reach wen.
  assign wen   = winc & ~wfull_q;
  assign waddr = wbin_q[A-1:0];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rbin_s = '0;
    for (int i = 0; i <= A; i++) begin
      rbin_s[i] = ^(wq2_rptr >> i);
    end

    wbin_d         = wbin_q + {{A{1'b0}}, wen};
    wptr_d         = (wbin_d >> 1) ^ wbin_d;
    // Full when the next Gray pointer is one lap ahead: two MSBs inverted, rest equal.
    wfull_d        = (wptr_d == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]});
    wlevel_d       = wbin_d - rbin_s;
    walmost_full_d = (wlevel_d >= THRESH);
    wovf_d         = wovf_q | (winc & wfull_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q         <= '0;
      wptr_q         <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wlevel_q       <= '0;
      wovf_q         <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wptr_q         <= wptr_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      wlevel_q       <= wlevel_d;
      wovf_q         <= wovf_d;
    end
  end

  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wlevel       = wlevel_q;
  assign wovf         = wovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full (ADDR_SIZE=4, ALMOST_FULL_THRESH=12): reset,
// fill, overflow, drain release, almost-full and pointer wrap-around.
module tb_fifo_wptr_full;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       winc;
  logic [4:0] wq2_rptr;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       wovf;

  int checks = 0;
  int errors = 0;

  fifo_wptr_full #(.ADDR_SIZE(4), .ALMOST_FULL_THRESH(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .wen          (wen),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .wovf         (wovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    winc     = 1'b0;
    wq2_rptr = '0;
    rst_n    = 1'b0;
    #2;
    rst_n    = 1'b1;
  endtask

  function automatic logic [4:0] gray(input logic [4:0] b);
    return (b >> 1) ^ b;
  endfunction

  logic [4:0] rp;

  initial begin
    rst_n    = 1'b0;
    winc     = 1'b0;
    wq2_rptr = '0;
    tick();
    tick();
    check("rst_wptr",   wptr,   0);
    check("rst_wfull",  wfull,  0);
    check("rst_wlevel", wlevel, 0);
    check("rst_wovf",   wovf,   0);
    check("rst_waddr",  waddr,  0);
    check("rst_wen",    wen,    0);
    rst_n = 1'b1;

    // Reset mid-operation, asserted between edges.
    winc = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_wptr",   wptr,   5'b00111);
    check("pre_rst_wlevel", wlevel, 5);
    winc  = 1'b0;
    rst_n = 1'b0;
    #2;
    check("async_rst_wptr",   wptr,   0);
    check("async_rst_wlevel", wlevel, 0);
    check("async_rst_wfull",  wfull,  0);
    check("async_rst_wovf",   wovf,   0);
    check("async_rst_waddr",  waddr,  0);
    check("async_rst_wen",    wen,    0);
    rst_n = 1'b1;
    winc  = 1'b1;
    tick();
    check("post_rst_wptr", wptr, 5'b00001);

    // Fill from empty with wq2_rptr held at 0; almost-full threshold crossing.
    do_reset();
    winc = 1'b1;
    tick(); check("fill_wptr1", wptr, 5'b00001);
    tick(); check("fill_wptr2", wptr, 5'b00011);
    tick(); check("fill_wptr3", wptr, 5'b00010);
    tick(); check("fill_wptr4", wptr, 5'b00110);
    for (int i = 5; i <= 11; i++) tick();
    check("af_after11",    walmost_full, 0);
    check("level_after11", wlevel,       11);
    tick();
    check("af_after12", walmost_full, 1);
    for (int i = 13; i <= 15; i++) tick();
    check("full_after15", wfull, 0);
    check("wptr_after15", wptr,  gray(5'd15));
    tick();
    check("full_after16",   wfull,  1);
    check("wptr_after16",   wptr,   5'b11000);
    check("wlevel_after16", wlevel, 16);
    check("waddr_after16",  waddr,  0);

    // Overflow: winc held while full.
    check("ovf_wen", wen, 0);
    tick();
    check("ovf_wptr",  wptr,  5'b11000);
    check("ovf_wovf",  wovf,  1);
    check("ovf_wfull", wfull, 1);
    check("ovf_level", wlevel, 16);

    // Drain release: write in the same cycle as the rptr change is still rejected.
    wq2_rptr = 5'b00001;
    check("rel_wen_blocked", wen, 0);
    tick();
    check("rel_wfull",  wfull,  0);
    check("rel_wlevel", wlevel, 15);
    check("rel_wptr",   wptr,   5'b11000);
    check("rel_wen",    wen,    1);
    tick();
    check("refill_wfull", wfull,  1);
    check("refill_wptr",  wptr,   5'b11001);
    check("refill_level", wlevel, 16);
    check("refill_waddr", waddr,  1);
    winc     = 1'b0;
    wq2_rptr = 5'b11001;
    tick();
    check("drain_level", wlevel, 0);
    check("drain_wfull", wfull,  0);
    check("drain_wovf",  wovf,   1);

    // Almost-full drops when the read pointer advances.
    do_reset();
    winc = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("af_set", walmost_full, 1);
    winc     = 1'b0;
    wq2_rptr = 5'b00001;
    tick();
    check("af_drop",       walmost_full, 0);
    check("af_drop_level", wlevel,       11);

    // Wrap: reader trails the writer by 3 across 40 writes.
    do_reset();
    winc = 1'b1;
    for (int n = 0; n < 40; n++) begin
      rp       = (n + 1 >= 3) ? 5'(n + 1 - 3) : 5'd0;
      wq2_rptr = gray(rp);
      tick();
      check("wrap_wfull", wfull, 0);
      check("wrap_waddr", waddr, 32'((n + 1) % 16));
      check("wrap_level", wlevel, (n + 1 < 3) ? 32'(n + 1) : 32'd3);
      if (n + 1 == 32) check("wrap_wptr32", wptr, 0);
    end
    winc = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
